mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle 32-bit multiply/divide unit that produces the 64-bit Z result pair.
- Sits directly upstream of the bus multiplexer; its zhi/zlo outputs drive bus select codes 5'd18 (ZHI) and 5'd19 (ZLO).
- Operands are captured from the bus-side A/B inputs on start. Results are held until the next operation completes.

Parameters:
- WIDTH, 32, operand width. zhi and zlo are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 = MUL signed, 01 = DIV signed, 10 = MULU, 11 = DIVU (see Optional Feature)
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while in RUN or DONE
- done  out  1  one-cycle pulse when results are valid
- div_by_zero  out  1  sticky flag for the last operation
- zhi  out  WIDTH  product high word / remainder
- zlo  out  WIDTH  product low word / quotient

Behaviour:
- Clock and reset: one clock, clk. clr_n is asynchronous, active-low.
- While clr_n is low: state = IDLE; busy, done, div_by_zero = 0; zhi, zlo = 0; internal counters and accumulators = 0.
- FSM states IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start = 1 at a clock edge latches a, b and op.
  - Signed ops record the operand signs and load their magnitudes.
  - Counter is loaded with WIDTH; go to RUN.
- RUN:
  - One radix-2 step per cycle.
  - MUL: shift-add on a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract on a WIDTH+1-bit partial remainder.
  - Counter decrements each cycle; after WIDTH steps go to DONE.
- DONE (exactly one cycle):
  - done = 1; sign-corrected results appear on zhi/zlo in this same cycle.
  - Next edge returns to IDLE.
- Latency: the start edge is edge 0, and done is high during the cycle after edge WIDTH+1. Every op, including divide-by-zero, uses this uniform latency.
- Throughput: at most one operation per WIDTH+2 cycles.
- start while busy is ignored, with no queuing. start in the same cycle done is high is also ignored.
- MUL result: full 2*WIDTH product; zhi = upper word, zlo = lower word. Signed product is negated when the operand signs differ.
- DIV result: quotient truncates toward zero; remainder takes the dividend's sign.
  - zlo = quotient, zhi = remainder.
- b = 0 on a DIV op: div_by_zero = 1, zlo = all ones, zhi = a (unmodified dividend).
- Signed overflow (most-negative / -1): zlo = most-negative value, zhi = 0, div_by_zero = 0.
- div_by_zero updates only in DONE and holds until the next DONE.
- zhi/zlo change only in DONE (or on reset); they are stable at all other times.
- Reset asserted mid-RUN aborts the operation: done is never pulsed and outputs return to reset values.

Optional Feature:
- Macro MUL_DIV_UNSIGNED_EN.
- Defined: op[1] selects unsigned variants (MULU, DIVU). Operands are treated as magnitudes, with no sign correction. The overflow special case does not apply.
- Undefined: op[1] is ignored, op[0] alone selects MUL/DIV, and all operations are signed. Unsigned datapath logic is not synthesised.

Decomposition:
- Package mul_div_pkg:
  - op encodings OP_MUL, OP_DIV, OP_MULU, OP_DIVU
  - state enum IDLE/RUN/DONE
  - bus select constants SEL_ZHI = 5'd18 and SEL_ZLO = 5'd19, shared with the bus multiplexer and control unit
- One sub-module, mul_div_signfix: combinational absolute value on input and conditional two's-complement negation of the results. It is instantiated for the operand path and for the result path.
- The FSM and shift datapath stay in mul_div_unit.

Test Plan:
1. MUL a = 7, b = -3 (0xFFFFFFFD) -> done pulses in the 34th cycle after start; zhi = 0xFFFFFFFF, zlo = 0xFFFFFFEB; busy low the following cycle.
2. MUL a = 0x7FFFFFFF, b = 0x7FFFFFFF -> zhi = 0x3FFFFFFF, zlo = 0x00000001.
3. DIV a = -17 (0xFFFFFFEF), b = 5 -> zlo = 0xFFFFFFFD, zhi = 0xFFFFFFFE, div_by_zero = 0.
4. DIV a = 100, b = 0 -> div_by_zero = 1, zlo = 0xFFFFFFFF, zhi = 0x00000064, same latency as case 1.
5. DIV a = 0x80000000, b = 0xFFFFFFFF -> zlo = 0x80000000, zhi = 0, div_by_zero = 0. With MUL_DIV_UNSIGNED_EN, DIVU 0xFFFFFFFF / 2 -> zlo = 0x7FFFFFFF, zhi = 1.
6. Start a MUL, pulse start again at cycle 5 with new operands, then drop clr_n at cycle 10 -> the second start is ignored; busy = 0 and zhi = zlo = 0 immediately (asynchronously); done never pulses; a fresh start after release completes normally.

Source files
------------

// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared op encodings, FSM states and Z bus select codes for the multiply/divide unit
package mul_div_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MULU = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bus multiplexer select codes that route zhi/zlo onto the bus
    localparam logic [4:0] SEL_ZHI = 5'd18;
    localparam logic [4:0] SEL_ZLO = 5'd19;

endpackage

// File: rtl/mul_div_signfix.sv
// rtl/mul_div_signfix.sv - conditional two's-complement negation (operand magnitude / result sign correction)
module mul_div_signfix #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle radix-2 multiply/divide producing the ZHI/ZLO pair
// Optional unsigned MULU/DIVU variants: define MUL_DIV_UNSIGNED_EN
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   bmag;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;

    logic               req_signed;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

`ifdef MUL_DIV_UNSIGNED_EN
    assign req_signed = ~op[1];
`else
    logic unused_op_hi;
    assign unused_op_hi = op[1];
    assign req_signed   = 1'b1;
`endif

    assign sgn_a = req_signed & a[WIDTH-1];
    assign sgn_b = req_signed & b[WIDTH-1];

    mul_div_signfix #(.N(WIDTH)) u_mag_a (.x(a), .neg(sgn_a), .y(mag_a));
    mul_div_signfix #(.N(WIDTH)) u_mag_b (.x(b), .neg(sgn_b), .y(mag_b));

    // acc low word holds multiplier (MUL) or dividend/quotient (DIV); bmag is multiplicand/divisor
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : '0);
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, bmag};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    mul_div_signfix #(.N(2*WIDTH)) u_fix_prod (.x(acc),            .neg(neg_q), .y(prod_fix));
    mul_div_signfix #(.N(WIDTH))   u_fix_quo  (.x(acc[WIDTH-1:0]), .neg(neg_q), .y(quo_fix));
    mul_div_signfix #(.N(WIDTH))   u_fix_rem  (.x(rem),            .neg(neg_r), .y(rem_fix));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // RUN spends WIDTH cycles stepping and one final cycle latching corrected results
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt         <= '0;
            acc         <= '0;
            rem         <= '0;
            bmag        <= '0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_by_zero <= 1'b0;
            zhi         <= '0;
            zlo         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        bmag   <= mag_b;
                        rem    <= '0;
                        cnt    <= CW'(WIDTH);
                        op_div <= op[0];
                        neg_q  <= sgn_a ^ sgn_b;
                        neg_r  <= sgn_a;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (op_div) begin
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
                            rem            <= div_diff[WIDTH] ? div_shift[WIDTH-1:0]
                                                              : div_diff[WIDTH-1:0];
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                    end else if (op_div) begin
                        // Divide by zero leaves rem = |a|, so rem_fix restores the raw dividend
                        div_by_zero <= (bmag == '0);
                        zlo         <= (bmag == '0) ? '1 : quo_fix;
                        zhi         <= rem_fix;
                    end else begin
                        div_by_zero <= 1'b0;
                        zhi         <= prod_fix[2*WIDTH-1:WIDTH];
                        zlo         <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk   = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] zhi, zlo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .zhi         (zhi),
        .zlo         (zlo)
    );

    always #5 clk = ~clk;

    // Drives one op; returns the cycle index (1 = cycle after start edge) in which done was seen
    // and whether zhi/zlo/div_by_zero stayed put until then. Ends at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output bit held);
        logic [W-1:0] h0, l0;
        logic         d0;
        @(negedge clk);
        h0 = zhi; l0 = zlo; d0 = div_by_zero;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        lat = 1; held = 1'b1;
        while (!done && lat < 100) begin
            if (zhi !== h0 || zlo !== l0 || div_by_zero !== d0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        checks++; if (zhi !== '0 || zlo !== '0) begin errors++; $display("FAIL reset_z got %h_%h want 0_0", zhi, zlo); end
        @(negedge clk); @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_mul;
        int lat; bit held;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, lat, held);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL mul1_latency got %0d want %0d", lat, LAT); end
        checks++; if (zhi !== 32'hFFFF_FFFF || zlo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul1_result got %h_%h want ffffffff_ffffffeb", zhi, zlo); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mul1_held got %b want 1", held); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul1_after busy=%b done=%b want 0 0", busy, done); end

        run_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, held);
        checks++; if (zhi !== 32'h3FFF_FFFF || zlo !== 32'h0000_0001) begin errors++; $display("FAIL mul2_result got %h_%h want 3fffffff_00000001", zhi, zlo); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mul2_held got %b want 1", held); end

        run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, held);
        checks++; if (zhi !== 32'h0 || zlo !== 32'd30) begin errors++; $display("FAIL mul3_result got %h_%h want 00000000_0000001e", zhi, zlo); end
    endtask

    task automatic test_div;
        int lat; bit held;
        run_op(2'b01, 32'hFFFF_FFEF, 32'd5, lat, held);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL div1_latency got %0d want %0d", lat, LAT); end
        checks++; if (zlo !== 32'hFFFF_FFFD || zhi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div1_result got q=%h r=%h want q=fffffffd r=fffffffe", zlo, zhi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div1_dbz got %b want 0", div_by_zero); end

        run_op(2'b01, 32'd17, 32'hFFFF_FFFB, lat, held);
        checks++; if (zlo !== 32'hFFFF_FFFD || zhi !== 32'd2) begin errors++; $display("FAIL div2_result got q=%h r=%h want q=fffffffd r=00000002", zlo, zhi); end
    endtask

    task automatic test_div_by_zero;
        int lat; bit held;
        run_op(2'b01, 32'd100, 32'd0, lat, held);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL dbz1_latency got %0d want %0d", lat, LAT); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz1_flag got %b want 1", div_by_zero); end
        checks++; if (zlo !== 32'hFFFF_FFFF || zhi !== 32'd100) begin errors++; $display("FAIL dbz1_result got q=%h r=%h want q=ffffffff r=00000064", zlo, zhi); end

        run_op(2'b01, 32'hFFFF_FF9C, 32'd0, lat, held);
        checks++; if (zlo !== 32'hFFFF_FFFF || zhi !== 32'hFFFF_FF9C) begin errors++; $display("FAIL dbz2_result got q=%h r=%h want q=ffffffff r=ffffff9c", zlo, zhi); end
        repeat (5) @(negedge clk);
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_sticky got %b want 1", div_by_zero); end

        run_op(2'b00, 32'd3, 32'd4, lat, held);
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL dbz_hold_run got %b want 1", held); end
        checks++; if (div_by_zero !== 1'b0 || zlo !== 32'd12) begin errors++; $display("FAIL dbz_clear got dbz=%b zlo=%h want 0 0000000c", div_by_zero, zlo); end
    endtask

    task automatic test_overflow;
        int lat; bit held;
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat, held);
        checks++; if (zlo !== 32'h8000_0000 || zhi !== 32'h0) begin errors++; $display("FAIL ovf_result got q=%h r=%h want q=80000000 r=00000000", zlo, zhi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_op_hi;
        int lat; bit held;
`ifdef MUL_DIV_UNSIGNED_EN
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2, lat, held);
        checks++; if (zlo !== 32'h7FFF_FFFF || zhi !== 32'd1) begin errors++; $display("FAIL divu_result got q=%h r=%h want q=7fffffff r=00000001", zlo, zhi); end
        run_op(2'b10, 32'hFFFF_FFFF, 32'd2, lat, held);
        checks++; if (zhi !== 32'd1 || zlo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulu_result got %h_%h want 00000001_fffffffe", zhi, zlo); end
`else
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2, lat, held);
        checks++; if (zlo !== 32'h0 || zhi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL op11_signed_div got q=%h r=%h want q=00000000 r=ffffffff", zlo, zhi); end
        run_op(2'b10, 32'hFFFF_FFFF, 32'd2, lat, held);
        checks++; if (zhi !== 32'hFFFF_FFFF || zlo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL op10_signed_mul got %h_%h want ffffffff_fffffffe", zhi, zlo); end
`endif
        checks++; if (lat !== LAT) begin errors++; $display("FAIL op_hi_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back;
        int lat; int extra;
        @(negedge clk);
        op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin a = 32'd100; b = 32'd100; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        checks++; if (zhi !== 32'h0 || zlo !== 32'd15) begin errors++; $display("FAIL b2b_result got %h_%h want 00000000_0000000f", zhi, zlo); end
        a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got busy=%b want 0", busy); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_no_queue got %0d dones want 0", extra); end
    endtask

    task automatic test_abort;
        int lat; bit held; int spurious;
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1 || zlo !== 32'd15) begin errors++; $display("FAIL abort_pre busy=%b zlo=%h want 1 0000000f", busy, zlo); end
        clr_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl busy=%b done=%b want 0 0", busy, done); end
        checks++; if (zhi !== '0 || zlo !== '0) begin errors++; $display("FAIL abort_z got %h_%h want 0_0", zhi, zlo); end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        spurious = 0;
        repeat (40) begin @(negedge clk); if (done || busy) spurious++; end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", spurious); end
        run_op(2'b00, 32'd6, 32'd7, lat, held);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_fresh_latency got %0d want %0d", lat, LAT); end
        checks++; if (zhi !== 32'h0 || zlo !== 32'd42) begin errors++; $display("FAIL abort_fresh_result got %h_%h want 00000000_0000002a", zhi, zlo); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_overflow();
        test_op_hi();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
